sdram_cmd_queue: RTL and testbench



---
 rtl/sdram_cmd_queue.sv | 154 +++++++++++++++
 tb/tb_sdram_cmd_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_queue.sv
// Client-side command/response queue in front of the SDRAM controller.
// Optional performance counters are enabled by defining SDRAM_Q_PERF_EN.
module sdram_cmd_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned MAX_RD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [25:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        read,
  output logic        write,
  output logic [25:0] addr,
  input  logic        cmd_ready,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  input  logic        data_read_val,
`ifdef SDRAM_Q_PERF_EN
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        rsp_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(MAX_RD);
  localparam int unsigned CW = RW + 1;
  localparam logic [AW:0]   CmdOne    = {{AW{1'b0}}, 1'b1};
  localparam logic [RW:0]   RspOne    = {{RW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CreditOne = {{RW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CreditMax = CW'(MAX_RD);

  typedef struct packed {
    logic        write;
    logic [25:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  // Command FIFO
  cmd_t        cmd_mem [DEPTH];
  logic [AW:0] cmd_wptr_q, cmd_rptr_q;
  cmd_t        cmd_head;
  logic        cmd_empty, cmd_full, cmd_push, cmd_pop;

  // Response FIFO
  logic [15:0] rsp_mem [MAX_RD];
  logic [RW:0] rsp_wptr_q, rsp_rptr_q;
  logic        rsp_empty, rsp_full, rsp_push, rsp_pop;

  logic [CW-1:0] credit_q, credit_d;
  logic          rsp_overflow_q;
  logic          issue, rd_issue;

  assign cmd_empty = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full  = (cmd_wptr_q[AW] != cmd_rptr_q[AW]) &&
                     (cmd_wptr_q[AW-1:0] == cmd_rptr_q[AW-1:0]);
  assign cmd_head  = cmd_mem[cmd_rptr_q[AW-1:0]];

  assign req_ready = !reset && !cmd_full;
  assign cmd_push  = req_valid && req_ready;

  // A read at the head without credit holds everything queued behind it.
  assign issue    = !reset && !cmd_empty && cmd_ready && (cmd_head.write || credit_q != '0);
  assign rd_issue = issue && !cmd_head.write;
  assign cmd_pop  = issue;

  assign read       = rd_issue;
  assign write      = issue && cmd_head.write;
  assign addr       = cmd_head.addr;
  assign data_write = cmd_head.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
    end else begin
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + CmdOne;
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + CmdOne;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wptr_q[AW-1:0]] <= {req_write, req_addr, req_wdata};
  end

  assign rsp_empty = (rsp_wptr_q == rsp_rptr_q);
  assign rsp_full  = (rsp_wptr_q[RW] != rsp_rptr_q[RW]) &&
                     (rsp_wptr_q[RW-1:0] == rsp_rptr_q[RW-1:0]);

  assign rsp_valid    = !reset && !rsp_empty;
  assign rsp_data     = rsp_mem[rsp_rptr_q[RW-1:0]];
  assign rsp_pop      = rsp_valid && rsp_ready;
  // A simultaneous pop frees the slot the incoming word needs.
  assign rsp_push     = !reset && data_read_val && (!rsp_full || rsp_pop);
  assign rsp_overflow = !reset && rsp_overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wptr_q     <= '0;
      rsp_rptr_q     <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RspOne;
      if (rsp_pop)  rsp_rptr_q <= rsp_rptr_q + RspOne;
      if (data_read_val && rsp_full && !rsp_pop) rsp_overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem[rsp_wptr_q[RW-1:0]] <= data_read;
  end

  always_comb begin
    credit_d = credit_q;
    if (rd_issue && !rsp_pop) begin
      credit_d = credit_q - CreditOne;
    end else if (!rd_issue && rsp_pop && credit_q != CreditMax) begin
      credit_d = credit_q + CreditOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= CreditMax;
    else       credit_q <= credit_d;
  end

`ifdef SDRAM_Q_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (read)  perf_rd_q <= perf_rd_q + 32'd1;
      if (write) perf_wr_q <= perf_wr_q + 32'd1;
      if (!cmd_empty && cmd_ready && !issue) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_sdram_cmd_queue.sv
// Bench for sdram_cmd_queue: directed vector table, corner sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_sdram_cmd_queue;
  localparam int DEPTH  = 8;
  localparam int MAX_RD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [25:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        read, write;
  logic [25:0] addr;
  logic        cmd_ready;
  logic [15:0] data_write, data_read;
  logic        data_read_val;
  logic        rsp_overflow;
`ifdef SDRAM_Q_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  sdram_cmd_queue #(
    .DEPTH (DEPTH),
    .MAX_RD(MAX_RD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .read         (read),
    .write        (write),
    .addr         (addr),
    .cmd_ready    (cmd_ready),
    .data_write   (data_write),
    .data_read    (data_read),
    .data_read_val(data_read_val),
`ifdef SDRAM_Q_PERF_EN
    .perf_rd_cnt   (perf_rd_cnt),
    .perf_wr_cnt   (perf_wr_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .rsp_overflow (rsp_overflow)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        w;
    logic [25:0] a;
    logic [15:0] d;
  } mcmd_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } ret_t;

  // Reference model: plain queues plus issued/popped read tallies.
  mcmd_t       mq[$];
  logic [15:0] mr[$];
  ret_t        rets[$];
  int          m_issued = 0, m_popped = 0, last_due = 0;
  bit          m_ovf = 1'b0;
  bit          auto_ret = 1'b0;
  int          rd_seen = 0, wr_seen = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk26(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Checks the DUT against the model mid-cycle, advances the model, steps one clock.
  task automatic cycle();
    int    credit, due;
    logic  hw, exp_iss, exp_rv, pop, push_ok;
    mcmd_t c;
    ret_t  r;
    @(negedge clk);
    if (reset) begin
      chk1("rst_read", read, 1'b0);
      chk1("rst_write", write, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_overflow", rsp_overflow, 1'b0);
      mq.delete();
      mr.delete();
      rets.delete();
      m_issued = 0;
      m_popped = 0;
      m_ovf    = 1'b0;
      last_due = 0;
    end else begin
      credit  = MAX_RD - (m_issued - m_popped);
      hw      = 1'b0;
      if (mq.size() != 0) hw = mq[0].w;
      exp_iss = (mq.size() != 0) && cmd_ready && (hw || credit > 0);
      exp_rv  = (mr.size() != 0);
      push_ok = (mq.size() < DEPTH);
      chk1("m_req_ready", req_ready, push_ok);
      chk1("m_read", read, exp_iss && !hw);
      chk1("m_write", write, exp_iss && hw);
      chk1("m_rsp_valid", rsp_valid, exp_rv);
      chk1("m_overflow", rsp_overflow, m_ovf);
      if (mq.size() != 0) begin
        chk26("m_addr", addr, mq[0].a);
        chk16("m_data_write", data_write, mq[0].d);
      end
      if (exp_rv) chk16("m_rsp_data", rsp_data, mr[0]);
      if (read) rd_seen++;
      if (write) wr_seen++;
      pop = exp_rv && rsp_ready;
      if (exp_iss) begin
        if (!hw) begin
          m_issued++;
          if (auto_ret) begin
            due = cyc + int'($urandom_range(1, 4));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due = due;
            r.d   = 16'($urandom);
            rets.push_back(r);
          end
        end
        void'(mq.pop_front());
      end
      if (req_valid && push_ok) begin
        c.w = req_write;
        c.a = req_addr;
        c.d = req_wdata;
        mq.push_back(c);
      end
      if (pop) begin
        void'(mr.pop_front());
        m_popped++;
      end
      if (data_read_val) begin
        if (mr.size() < MAX_RD) mr.push_back(data_read);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (auto_ret) begin
      if (rets.size() != 0 && rets[0].due <= cyc) begin
        data_read_val = 1'b1;
        data_read     = rets[0].d;
        void'(rets.pop_front());
      end else begin
        data_read_val = 1'b0;
      end
    end
  endtask

  task automatic push_req(input logic w, input logic [25:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    cycle();
    req_valid = 1'b0;
  endtask

  typedef struct packed {
    logic        rv, w;
    logic [25:0] a;
    logic [15:0] d;
    logic        cr, rr, dv;
    logic [15:0] dr;
    logic        e_rq, e_rd, e_wr, e_rv, ca;
    logic [25:0] e_a;
    logic [15:0] e_dw;
    logic        cd;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vt[8];

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; cmd_ready = 1'b0; data_read = '0; data_read_val = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;

    // Write then read, data returned three cycles after the read strobe.
    vt[0] = '{rv:1'b1, w:1'b1, a:26'h10, d:16'hBEEF, cr:1'b1, e_rq:1'b1, default:'0};
    vt[1] = '{rv:1'b1, a:26'h10, cr:1'b1, e_rq:1'b1, e_wr:1'b1, ca:1'b1, e_a:26'h10,
              e_dw:16'hBEEF, default:'0};
    vt[2] = '{cr:1'b1, e_rq:1'b1, e_rd:1'b1, ca:1'b1, e_a:26'h10, default:'0};
    vt[3] = '{cr:1'b1, e_rq:1'b1, default:'0};
    vt[4] = '{cr:1'b1, e_rq:1'b1, default:'0};
    vt[5] = '{cr:1'b1, dv:1'b1, dr:16'hBEEF, e_rq:1'b1, default:'0};
    vt[6] = '{cr:1'b1, rr:1'b1, e_rq:1'b1, e_rv:1'b1, cd:1'b1, e_rdata:16'hBEEF, default:'0};
    vt[7] = '{cr:1'b1, e_rq:1'b1, default:'0};
    for (int i = 0; i < 8; i++) begin
      req_valid = vt[i].rv; req_write = vt[i].w; req_addr = vt[i].a; req_wdata = vt[i].d;
      cmd_ready = vt[i].cr; rsp_ready = vt[i].rr;
      data_read_val = vt[i].dv; data_read = vt[i].dr;
      #1;
      chk1($sformatf("vec%0d_req_ready", i), req_ready, vt[i].e_rq);
      chk1($sformatf("vec%0d_read", i), read, vt[i].e_rd);
      chk1($sformatf("vec%0d_write", i), write, vt[i].e_wr);
      chk1($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].e_rv);
      if (vt[i].ca) begin
        chk26($sformatf("vec%0d_addr", i), addr, vt[i].e_a);
        chk16($sformatf("vec%0d_data_write", i), data_write, vt[i].e_dw);
      end
      if (vt[i].cd) chk16($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].e_rdata);
      cycle();
    end
    req_valid = 1'b0; rsp_ready = 1'b0; data_read_val = 1'b0;

    // Fill the command FIFO with the controller stalled, then drain in order.
    cmd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_req(1'(i % 2), 26'(32'h100 + i), 16'(32'hA000 + i));
    #1;
    chk1("fill_req_ready", req_ready, 1'b0);
    auto_ret = 1'b1; rsp_ready = 1'b1; cmd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk1($sformatf("fill_strobe%0d", i), read | write, 1'b1);
      chk1($sformatf("fill_kind%0d", i), write, 1'(i % 2));
      chk26($sformatf("fill_addr%0d", i), addr, 26'(32'h100 + i));
      cycle();
    end
    repeat (12) cycle();
    auto_ret = 1'b0; data_read_val = 1'b0; rsp_ready = 1'b0;

    // Credit limit: six reads, only MAX_RD issue until a response is popped.
    rd_seen = 0;
    for (int i = 0; i < 6; i++) push_req(1'b0, 26'(32'h200 + i), 16'h0);
    repeat (6) cycle();
    chk32("credit_burst", rd_seen, MAX_RD);
    for (int i = 0; i < MAX_RD; i++) begin
      data_read_val = 1'b1;
      data_read = 16'(32'hC000 + i);
      cycle();
    end
    data_read_val = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    repeat (4) cycle();
    chk32("credit_one_more", rd_seen, MAX_RD + 1);

    // Refill, then push and pop together on a full response FIFO.
    data_read_val = 1'b1; data_read = 16'hC004;
    cycle();
    rsp_ready = 1'b1; data_read = 16'hC005;
    cycle();
    rsp_ready = 1'b0; data_read_val = 1'b0;
    #1;
    chk1("sim_rsp_valid", rsp_valid, 1'b1);
    chk1("sim_overflow", rsp_overflow, 1'b0);
    chk16("sim_head", rsp_data, 16'hC002);

    // Overflow: data dropped, flag sticky, contents intact.
    data_read_val = 1'b1; data_read = 16'hDEAD;
    cycle();
    data_read_val = 1'b0;
    #1;
    chk1("ovf_set", rsp_overflow, 1'b1);
    repeat (3) cycle();
    chk1("ovf_sticky", rsp_overflow, 1'b1);
    chk16("ovf_head", rsp_data, 16'hC002);
    rsp_ready = 1'b1;
    repeat (6) cycle();
    rsp_ready = 1'b0;

    // Reset with commands queued and responses buffered.
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_req(1'b0, 26'(32'h300 + i), 16'h0);
    data_read_val = 1'b1; data_read = 16'h1111;
    cycle();
    data_read = 16'h2222;
    cycle();
    reset = 1'b1; data_read = 16'h3333;
    cycle();
    reset = 1'b0; data_read_val = 1'b0; cmd_ready = 1'b1;
    #1;
    chk1("post_rst_read", read, 1'b0);
    chk1("post_rst_write", write, 1'b0);
    chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
    chk1("post_rst_req_ready", req_ready, 1'b1);
    chk1("post_rst_overflow", rsp_overflow, 1'b0);
    cycle();
    rd_seen = 0;
    for (int i = 0; i < 5; i++) push_req(1'b0, 26'(32'h400 + i), 16'h0);
    repeat (6) cycle();
    chk32("post_rst_burst", rd_seen, MAX_RD);

    // Random traffic with the bench acting as the controller.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    auto_ret = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 26'($urandom);
      req_wdata = 16'($urandom);
      cmd_ready = ($urandom_range(0, 9) < 7);
      rsp_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    req_valid = 1'b0; cmd_ready = 1'b1; rsp_ready = 1'b1;
    repeat (40) cycle();
    chk32("drain_cmd_empty", int'(rets.size()) + int'(mr.size()), 0);
    chk1("drain_rsp_valid", rsp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
